// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle synchronous program memory and
// queues returned words (tagged with their PC) for decode. Optional bypass: IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int                BIT_WIDTH      = 32,
  parameter int                ADDR_WIDTH     = 32,
  parameter int                MEM_ADDR_WIDTH = 6,
  parameter int                DEPTH          = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  localparam int               PW             = $clog2(DEPTH),
  localparam int               CW             = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [BIT_WIDTH-1:0]      mem_q,
  input  logic                      id_stall,
  output logic                      id_valid,
  output logic [BIT_WIDTH-1:0]      id_instruction,
  output logic [ADDR_WIDTH-1:0]     id_pc,
  output logic [ADDR_WIDTH-1:0]     id_pc_plus4,
  output logic [CW-1:0]             count
);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BIT_WIDTH-1:0]  instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];

  logic          head_valid, issue, push, pop, bypass;
  logic [CW:0]   occupancy;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign head_valid     = (count_q != '0);
  // The outstanding read reserves a slot so a returning word always has room.
  assign occupancy      = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue          = !redirect && (occupancy < (CW+1)'(DEPTH));

`ifdef IFQ_BYPASS_EN
  assign bypass = !head_valid && inflight_q && !redirect && !id_stall;
`else
  assign bypass = 1'b0;
`endif

  assign push      = inflight_q && !redirect && !bypass;
  assign pop       = head_valid && !id_stall && !redirect;
  assign mem_rd_en = issue && !rst;
  assign mem_addr  = fetch_pc_q[MEM_ADDR_WIDTH+1:2];
  assign count     = count_q;

  always_comb begin
    id_valid       = 1'b0;
    id_instruction = '0;
    id_pc          = '0;
    if (bypass) begin
      id_valid       = 1'b1;
      id_instruction = mem_q;
      id_pc          = req_pc_q;
    end else if (head_valid) begin
      id_valid       = 1'b1;
      id_instruction = instr_mem[rd_ptr_q];
      id_pc          = pc_mem[rd_ptr_q];
    end
  end

  assign id_pc_plus4 = id_pc + ADDR_WIDTH'(4);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        req_pc_d   = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: count_q gates every read.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PW'(gi))) begin
          instr_mem[gi] <= mem_q;
          pc_mem[gi]    <= req_pc_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: scoreboard of issued reads plus a phase table
// and directed sequences for stall, redirect, PC wrap and asynchronous reset.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_q = '0;
  logic        id_stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instruction, id_pc, id_pc_plus4;
  logic [2:0]  count;

  instr_fetch_queue #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(6),
                      .DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_q(mem_q),
    .id_stall(id_stall), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .count(count)
  );

  always #5 clk = ~clk;

  // Program memory: 1-cycle synchronous read returning A000_0000 | word address.
  always @(posedge clk) if (mem_rd_en) mem_q <= 32'hA000_0000 | {26'd0, mem_addr};

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        sb[$];
  logic [31:0] model_pc = '0;
  bit          inflight_m = 1'b0;
  int          tests = 0, fails = 0;

  logic        s_rd, s_valid;
  logic [2:0]  s_count;
  logic [5:0]  s_addr;
  logic [31:0] s_pc, s_plus4;

  typedef struct {
    int n; bit stall; bit redir; logic [31:0] rpc;
    bit chk_cnt; logic [2:0] exp_cnt; bit chk_rd; bit exp_rd;
    bit chk_valid; bit exp_valid; bit chk_pc; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    bit   exp_rd;
    s_rd = mem_rd_en; s_valid = id_valid; s_count = count;
    s_addr = mem_addr; s_pc = id_pc; s_plus4 = id_pc_plus4;
    if (rst) begin
      sb.delete(); model_pc = '0; inflight_m = 1'b0;
      return;
    end
    exp_rd = !redirect && (sb.size() < DEPTH);
    chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, exp_rd});
    chk("count", {29'd0, count}, 32'(sb.size() - int'(inflight_m)));
    if (!id_valid) begin
      chk("idle_instr", id_instruction, 32'd0);
      chk("idle_pc", id_pc, 32'd0);
    end
    if (redirect) begin
      sb.delete();
      model_pc   = {redirect_pc[31:2], 2'b00};
      inflight_m = 1'b0;
    end else begin
      if (id_valid && !id_stall) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL pop_empty: got pc %h expected no valid entry", id_pc);
        end else begin
          e = sb.pop_front();
          $display("[TB] pop pc=%h instr=%h", id_pc, id_instruction);
          chk("id_pc", id_pc, e.pc);
          chk("id_instruction", id_instruction, e.instr);
          chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
        end
      end
      if (exp_rd) begin
        chk("mem_addr", {26'd0, mem_addr}, {26'd0, model_pc[7:2]});
        e.pc    = model_pc;
        e.instr = 32'hA000_0000 | {26'd0, model_pc[7:2]};
        sb.push_back(e);
        model_pc = model_pc + 32'd4;
      end
      inflight_m = exp_rd;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; id_stall = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, first_valid, lows, k;

    tbl[0] = '{12, 1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[1] = '{8,  1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{8,  1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1,  1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1,  1'b1, 1'b0, 32'h0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1,  1'b1, 1'b1, 32'h43, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{1,  1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    // Reset state
    #1 rst = 1'b1;
    step();
    chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instruction, 32'd0);
    step();
    rst = 1'b0;

    // Streaming latency from the first request
    first_rd = -1; first_valid = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_rd && first_rd < 0) first_rd = i;
      if (s_valid && first_valid < 0) first_valid = i;
    end
    chk("first_rd_cycle", first_rd, 0);
    chk("first_latency", first_valid - first_rd, LAT);

    // Stall fill, drain, and redirect with a full queue and a read in flight
    do_reset();
    for (int v = 0; v < 7; v++) begin
      id_stall = tbl[v].stall; redirect = tbl[v].redir; redirect_pc = tbl[v].rpc;
      for (int c = 0; c < tbl[v].n; c++) step();
      $display("[TB] vector %0d count=%0d rd=%0b valid=%0b pc=%h", v, s_count, s_rd, s_valid, s_pc);
      if (tbl[v].chk_cnt)   chk("vec_count", {29'd0, s_count}, {29'd0, tbl[v].exp_cnt});
      if (tbl[v].chk_rd)    chk("vec_rd_en", {31'd0, s_rd}, {31'd0, tbl[v].exp_rd});
      if (tbl[v].chk_valid) chk("vec_valid", {31'd0, s_valid}, {31'd0, tbl[v].exp_valid});
      if (tbl[v].chk_pc)    chk("vec_head_pc", s_pc, tbl[v].exp_pc);
    end
    lows = 1;
    for (k = 0; k < 10; k++) begin
      step();
      if (s_valid) break;
      lows++;
    end
    chk("redirect_gap", lows, LAT);
    chk("redirect_target_pc", s_pc, 32'h40);
    for (int i = 0; i < 6; i++) step();

    // PC wrap through 0xFFFFFFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_rd_en", {31'd0, s_rd}, 32'd1);
    chk("wrap_addr_hi", {26'd0, s_addr}, 32'd63);
    step();
    chk("wrap_addr_lo", {26'd0, s_addr}, 32'd0);
    k = 0;
    while (!s_valid && k < 10) begin step(); k++; end
    chk("wrap_first_pc", s_pc, 32'hFFFF_FFFC);
    chk("wrap_first_plus4", s_plus4, 32'd0);
    step();
    chk("wrap_second_pc", s_pc, 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("async_id_valid", {31'd0, id_valid}, 32'd0);
    chk("async_count", {29'd0, count}, 32'd0);
    chk("async_rd_en", {31'd0, mem_rd_en}, 32'd0);
    step(); step();
    rst = 1'b0;
    k = 0;
    step();
    while (!s_valid && k < 10) begin step(); k++; end
    chk("restart_pc", s_pc, 32'd0);
    for (int i = 0; i < 6; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
